keypad_scanner: RTL and testbench

//  4x4 matrix-keypad scanner feeding the parking-meter core's keyboard inputs.
//  - Drives columns active-low one at a time and reads pulled-up rows.
//  - Debounces press and release.
//  - Presents a 4-bit key code plus a NoShut "key held" level.
//  - The core acts on the NoShut falling edge, so KeyCode stays stable through and after release.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_row_sync.sv | 34 +++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner and the parking-meter core:
//   state_t      scanner FSM states
//   KEY_MAP      key code for each [row][col] position (col0 = Col[0])
//   KEY_START / KEY_CLEAR / KEY_CONFIRM   codes the core treats as commands
//   low_count()  number of active-low bits in a 4-bit vector
//   low_index()  index of the lowest active-low bit in a 4-bit vector
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   // Physical layout of the keypad, indexed [row][col]
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'd1,  4'd2, 4'd3,  4'd10},
      '{4'd4,  4'd5, 4'd6,  4'd11},
      '{4'd7,  4'd8, 4'd9,  4'd12},
      '{4'd14, 4'd0, 4'd15, 4'd13}
   };

   localparam logic [3:0] KEY_START   = 4'd11;
   localparam logic [3:0] KEY_CLEAR   = 4'd12;
   localparam logic [3:0] KEY_CONFIRM = 4'd13;

   // Counts how many lines of an active-low vector are asserted
   function automatic logic [2:0] low_count(input logic [3:0] v);
      low_count = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!v[i]) low_count = low_count + 3'd1;
      end
   endfunction

   // Index of the lowest asserted line; used on one-hot-low vectors only
   function automatic logic [1:0] low_index(input logic [3:0] v);
      low_index = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) low_index = 2'(i);
      end
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// -----------------------------------------------------------------------------
// keypad_row_sync
// Brings the asynchronous, active-low keypad rows into the CLK domain through
// STAGES register stages (1 or 2). All stages reset to 4'b1111 (no key).
// Ports:
//   CLK   in  1  system clock
//   RSTn  in  1  asynchronous active-low reset
//   d     in  4  raw keypad rows
//   q     out 4  synchronised rows
// -----------------------------------------------------------------------------
module keypad_row_sync #(
   parameter int STAGES = 2
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] stg [STAGES];

   // Shift chain; the idle level of the rows is all-high, so reset to that
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= 4'b1111;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad scanner: walks an active-low column ring, debounces the
// press and release of a single key, and presents the key code plus a
// "key held" level (NoShut) to the parking-meter core. KeyCode is only
// updated when a press is accepted, so it is stable across the NoShut fall.
// Ports:
//   CLK      in  1  system clock
//   RSTn     in  1  asynchronous active-low reset
//   Row      in  4  keypad rows, active-low, asynchronous
//   Col      out 4  column drive, active-low, exactly one bit low
//   KeyCode  out 4  last accepted key code
//   NoShut   out 1  high while the accepted key is held
// Build option:
//   ROW_SYNC_EN  defined: 2-flop row synchroniser; undefined: single stage.
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 5000,
   parameter int DEB_CYCLES = 20000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] KeyCode,
   output logic       NoShut
);

`ifdef ROW_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

   localparam int MAX_CNT = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
   localparam int CW      = $clog2(MAX_CNT);

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   div;
   logic [CW-1:0]   cnt;
   logic [1:0]      row_idx;
   logic [3:0]      rs;
   logic            row_high;
   logic            div_end;
   logic            deb_end;
   logic            one_low;

   keypad_row_sync #(.STAGES(SYNC_STAGES)) u_row_sync (
      .CLK  (CLK),
      .RSTn (RSTn),
      .d    (Row),
      .q    (rs)
   );

   assign row_high = rs[row_idx];
   assign div_end  = (div == CW'(SCAN_DIV - 1));
   assign deb_end  = (cnt == CW'(DEB_CYCLES - 1));
   // Two or more rows low means several keys on this column: ignore them
   assign one_low  = (low_count(rs) == 3'd1);

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= SCAN;
      else       state <= state_nx;
   end

   // Next-state logic; only the latched row matters once a key is captured
   always_comb begin
      state_nx = state;
      case (state)
         SCAN:      if (div_end && one_low) state_nx = DEB_PRESS;
         DEB_PRESS: if (row_high)           state_nx = SCAN;
                    else if (deb_end)       state_nx = HELD;
         HELD:      if (row_high)           state_nx = DEB_REL;
         DEB_REL:   if (!row_high)          state_nx = HELD;
                    else if (deb_end)       state_nx = SCAN;
         default:                           state_nx = SCAN;
      endcase
   end

   // NoShut is decoded from state bit 1 only, so it cannot glitch
   always_comb begin
      NoShut = (state == HELD) || (state == DEB_REL);
   end

   // Column ring, slot divider, debounce counter, latched row and key code.
   // The ring is frozen from capture until the release is accepted; leaving
   // DEB_REL moves on to the next column with a fresh slot.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         Col     <= 4'b1110;
         div     <= '0;
         cnt     <= '0;
         row_idx <= 2'd0;
         KeyCode <= 4'd0;
      end else begin
         case (state)
            SCAN: begin
               if (div_end) begin
                  div <= '0;
                  if (one_low) begin
                     row_idx <= low_index(rs);
                     cnt     <= '0;
                  end else begin
                     Col <= {Col[2:0], Col[3]};
                  end
               end else begin
                  div <= div + CW'(1);
               end
            end
            DEB_PRESS: begin
               if (row_high) begin
                  cnt <= '0;
               end else if (deb_end) begin
                  cnt     <= '0;
                  KeyCode <= KEY_MAP[row_idx][low_index(Col)];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HELD: begin
               if (row_high) cnt <= '0;
            end
            DEB_REL: begin
               if (!row_high) begin
                  cnt <= '0;
               end else if (deb_end) begin
                  cnt <= '0;
                  div <= '0;
                  Col <= {Col[2:0], Col[3]};
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               cnt <= '0;
               div <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_DIV=4, DEB_CYCLES=8. A small keypad model
// turns pressed keys into row levels for whichever column is driven. Each
// intended key acceptance pushes its code into expectQ; the monitor checks
// KeyCode against it on every NoShut rise and pops it on the NoShut fall.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV   = 4;
   localparam int DEB_CYCLES = 8;
`ifdef ROW_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 1;
`endif

   // Key positions, index = row*4 + col
   localparam int K1 = 0;
   localparam int K5 = 5;
   localparam int K7 = 8;
   localparam int K9 = 10;
   localparam int KB = 7;
   localparam int KC = 11;
   localparam int KD = 15;

   logic        CLK  = 1'b0;
   logic        RSTn = 1'b0;
   logic [3:0]  Row;
   logic [3:0]  Col;
   logic [3:0]  KeyCode;
   logic        NoShut;
   logic [15:0] keyDown = '0;

   int testsRun    = 0;
   int testsFailed = 0;
   int riseCount   = 0;
   int pushCount   = 0;
   logic [3:0] expectQ [$];
   logic prevNoShut = 1'b0;

   always #5 CLK = ~CLK;

   keypad_scanner #(
      .SCAN_DIV   (SCAN_DIV),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .Row     (Row),
      .Col     (Col),
      .KeyCode (KeyCode),
      .NoShut  (NoShut)
   );

   // Keypad matrix: a pressed key pulls its row low when its column is driven
   always_comb begin
      Row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keyDown[r*4+c] && (Col[c] === 1'b0)) Row[r] = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input int holdCycles);
      keyDown = keys;
      repeat (holdCycles) @(negedge CLK);
   endtask

   task automatic expectKey(input logic [3:0] code);
      expectQ.push_back(code);
      pushCount++;
   endtask

   // Waits (at negedges) for NoShut to reach level; returns cycles taken
   task automatic waitNoShut(input logic level, input int maxCycles,
                             input string what, output int cycles);
      cycles = 0;
      while (NoShut !== level && cycles < maxCycles) begin
         @(negedge CLK);
         cycles++;
      end
      if (NoShut !== level) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: NoShut is %b after %0d cycles, expected %b",
                  what, NoShut, cycles, level);
      end
   endtask

   // Waits for the first cycle in which Col newly shows target
   task automatic waitColEntry(input logic [3:0] target, input string what);
      int n = 0;
      while (Col === target && n < 40) begin
         @(negedge CLK);
         n++;
      end
      while (Col !== target && n < 40) begin
         @(negedge CLK);
         n++;
      end
      if (Col !== target) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: Col is %b, expected %b within 40 cycles", what, Col, target);
      end
   endtask

   // Monitor: KeyCode must match the expected key on each NoShut edge. A fall
   // caused by reset abandons the expected key and must show the reset code.
   always @(posedge CLK) begin
      #2;
      if (NoShut === 1'b1 && prevNoShut === 1'b0) begin
         riseCount++;
         if (expectQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_rise: NoShut rose with KeyCode %0d, expected no key", KeyCode);
         end else begin
            checkOutput("rise_keycode", KeyCode, expectQ[0]);
         end
      end else if (NoShut === 1'b0 && prevNoShut === 1'b1) begin
         if (expectQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_fall: NoShut fell with KeyCode %0d, expected no key", KeyCode);
         end else if (RSTn === 1'b0) begin
            void'(expectQ.pop_front());
            checkOutput("reset_fall_keycode", KeyCode, 0);
         end else begin
            checkOutput("fall_keycode", KeyCode, expectQ.pop_front());
         end
      end
      prevNoShut = NoShut;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [3:0] scanSeq [5];
      logic [15:0] keys;
      int cyc;

      scanSeq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

      // 1. Reset values and free-running column ring
      applyStimulus('0, 3);
      checkOutput("reset_col", Col, 4'b1110);
      checkOutput("reset_keycode", KeyCode, 0);
      checkOutput("reset_noshut", NoShut, 0);
      RSTn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         repeat (SCAN_DIV) @(negedge CLK);
         checkOutput($sformatf("scan_col_%0d", i), Col, scanSeq[i]);
      end
      checkOutput("idle_noshut", NoShut, 0);
      checkOutput("idle_keycode", KeyCode, 0);

      // 2. Press '5': Col reaches 1101 at edge E0, capture at E0+4,
      //    acceptance 8 edges later
      waitColEntry(4'b1110, "key5_align");
      expectKey(4'd5);
      keyDown = 16'(1) << K5;
      waitColEntry(4'b1101, "key5_col");
      waitNoShut(1'b1, 60, "key5_press", cyc);
      checkOutput("key5_press_latency", cyc, SCAN_DIV + DEB_CYCLES);
      applyStimulus(keyDown, 3);
      checkOutput("key5_col_frozen", Col, 4'b1101);
      checkOutput("key5_keycode_held", KeyCode, 5);
      //    Release: rs high after SYNC_LAT edges, HELD notices one edge
      //    later, then 8 debounce edges
      keyDown = '0;
      waitNoShut(1'b0, 60, "key5_release", cyc);
      checkOutput("key5_release_latency", cyc, SYNC_LAT + 1 + DEB_CYCLES);
      checkOutput("key5_next_col", Col, 4'b1011);
      applyStimulus('0, 6);
      checkOutput("key5_keycode_after", KeyCode, 5);

      // 3a. A 5-cycle glitch on '1' must not be accepted
      waitColEntry(4'b1110, "glitch_align");
      applyStimulus(16'(1) << K1, 5);
      applyStimulus('0, 30);
      checkOutput("glitch_noshut", NoShut, 0);
      checkOutput("glitch_rises", riseCount, pushCount);

      // 3b. '9' bouncing every 3 cycles for 24 cycles, then stable
      expectKey(4'd9);
      for (int i = 0; i < 8; i++) begin
         keys = (i % 2 == 0) ? (16'(1) << K9) : 16'(0);
         applyStimulus(keys, 3);
      end
      keyDown = 16'(1) << K9;
      waitNoShut(1'b1, 100, "key9_press", cyc);
      checkOutput("key9_single_rise", riseCount, pushCount);
      applyStimulus(keyDown, 4);
      keyDown = '0;
      waitNoShut(1'b0, 100, "key9_release", cyc);

      // 4. '1' and '7' share column 0: two rows low, nothing captured
      waitColEntry(4'b0111, "multi_align");
      keyDown = (16'(1) << K1) | (16'(1) << K7);
      waitColEntry(4'b1110, "multi_col0");
      for (int i = 0; i < 5; i++) begin
         repeat (SCAN_DIV) @(negedge CLK);
         checkOutput($sformatf("multi_col_%0d", i), Col, scanSeq[i]);
      end
      checkOutput("multi_noshut", NoShut, 0);
      applyStimulus('0, 2);

      // 5. B, C, D in sequence
      $display("[TB] command keys START/CLEAR/CONFIRM = %0d/%0d/%0d",
               KEY_START, KEY_CLEAR, KEY_CONFIRM);
      expectKey(4'd11);
      applyStimulus(16'(1) << KB, 0);
      waitNoShut(1'b1, 100, "keyB_press", cyc);
      applyStimulus(keyDown, 3);
      applyStimulus('0, 0);
      waitNoShut(1'b0, 100, "keyB_release", cyc);
      expectKey(4'd12);
      applyStimulus(16'(1) << KC, 0);
      waitNoShut(1'b1, 100, "keyC_press", cyc);
      applyStimulus(keyDown, 3);
      applyStimulus('0, 0);
      waitNoShut(1'b0, 100, "keyC_release", cyc);
      expectKey(4'd13);
      applyStimulus(16'(1) << KD, 0);
      waitNoShut(1'b1, 100, "keyD_press", cyc);
      applyStimulus(keyDown, 3);
      applyStimulus('0, 0);
      waitNoShut(1'b0, 100, "keyD_release", cyc);
      checkOutput("keyD_keycode_after", KeyCode, 13);

      // 6. Reset while '5' is held, then re-acquire it from scratch:
      //    Col reaches 1101 at edge 4, capture at 8, acceptance at 16
      expectKey(4'd5);
      applyStimulus(16'(1) << K5, 0);
      waitNoShut(1'b1, 100, "rst_key5_press", cyc);
      applyStimulus(keyDown, 2);
      RSTn = 1'b0;
      #1;
      checkOutput("rst_async_noshut", NoShut, 0);
      checkOutput("rst_async_col", Col, 4'b1110);
      checkOutput("rst_async_keycode", KeyCode, 0);
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      expectKey(4'd5);
      waitNoShut(1'b1, 60, "rst_reacquire", cyc);
      checkOutput("rst_reacquire_latency", cyc, 2 * SCAN_DIV + DEB_CYCLES);
      applyStimulus(keyDown, 3);
      applyStimulus('0, 0);
      waitNoShut(1'b0, 100, "rst_release", cyc);

      applyStimulus('0, 10);
      checkOutput("queue_empty", expectQ.size(), 0);
      checkOutput("total_rises", riseCount, pushCount);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
